// File: rtl/demux5_reg.sv
// Five-way registered demultiplexer: each accepted word lands in a one-entry
// buffer per channel; illegal selects are swallowed, flagged and counted.
module demux5_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       demuxFlag,
   input  logic [WIDTH-1:0] w_demuxIn,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] w_demuxOut0,
   output logic [WIDTH-1:0] w_demuxOut1,
   output logic [WIDTH-1:0] w_demuxOut2,
   output logic [WIDTH-1:0] w_demuxOut3,
   output logic [WIDTH-1:0] w_demuxOut4,
   output logic [4:0]       out_valid,
   input  logic [4:0]       out_ack,
   output logic             sel_err,
   output logic [3:0]       err_count
);

   localparam int          NCH      = 5;
   localparam logic [0:0]  ST_EMPTY = 1'b0;
   localparam logic [0:0]  ST_FULL  = 1'b1;
   localparam logic [3:0]  ERR_MAX  = 4'hF;

   // Handshake: a word moves when in_valid and in_ready are both high at a
   // rising edge. in_ready never looks at in_valid; a channel's consumer takes
   // its word when out_valid[i] and out_ack[i] are both high at a rising edge.

   logic [NCH-1:0]   state_q;
   logic [WIDTH-1:0] data_q [NCH];
   logic             sel_err_q;
   logic [3:0]       err_count_q;

   logic             legal;
   logic [NCH-1:0]   sel_oh;
   logic [NCH-1:0]   slot_free;
   logic             accept;
   logic [NCH-1:0]   wr;
   logic [NCH-1:0]   ack_eff;
   logic             drop;

   always_comb begin
      legal     = (demuxFlag <= 3'd4);
      sel_oh    = '0;
      if (legal) begin
         sel_oh = 5'b00001 << demuxFlag;
      end
      // A full slot can still take a word when its consumer empties it this edge.
      slot_free = ~state_q | out_ack;
      in_ready  = legal ? |(sel_oh & slot_free) : 1'b1;
      accept    = in_valid & in_ready;
      wr        = accept ? sel_oh : '0;
      ack_eff   = out_ack & state_q;
      drop      = accept & ~legal;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (wr[i]) begin
               state_q[i] <= ST_FULL;
               data_q[i]  <= w_demuxIn;
            end else if (ack_eff[i]) begin
               state_q[i] <= ST_EMPTY;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_err_q   <= 1'b0;
         err_count_q <= '0;
      end else begin
         sel_err_q <= drop;
         if (drop && (err_count_q != ERR_MAX)) begin
            err_count_q <= err_count_q + 4'd1;
         end
      end
   end

   assign out_valid   = state_q;
   assign w_demuxOut0 = data_q[0];
   assign w_demuxOut1 = data_q[1];
   assign w_demuxOut2 = data_q[2];
   assign w_demuxOut3 = data_q[3];
   assign w_demuxOut4 = data_q[4];
   assign sel_err     = sel_err_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_demux5_reg.sv
// Directed bench for demux5_reg: fixed vectors with hand-computed expectations,
// each compared through an immediate assertion.
module tb_demux5_reg;

   localparam int WIDTH = 32;

   logic             clk;
   logic             reset;
   logic [2:0]       demuxFlag;
   logic [WIDTH-1:0] w_demuxIn;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] w_demuxOut0;
   logic [WIDTH-1:0] w_demuxOut1;
   logic [WIDTH-1:0] w_demuxOut2;
   logic [WIDTH-1:0] w_demuxOut3;
   logic [WIDTH-1:0] w_demuxOut4;
   logic [4:0]       out_valid;
   logic [4:0]       out_ack;
   logic             sel_err;
   logic [3:0]       err_count;

   int n_assert = 0;
   int n_fail   = 0;

   demux5_reg #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .demuxFlag  (demuxFlag),
      .w_demuxIn  (w_demuxIn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .w_demuxOut0(w_demuxOut0),
      .w_demuxOut1(w_demuxOut1),
      .w_demuxOut2(w_demuxOut2),
      .w_demuxOut3(w_demuxOut3),
      .w_demuxOut4(w_demuxOut4),
      .out_valid  (out_valid),
      .out_ack    (out_ack),
      .sel_err    (sel_err),
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [2:0] flag, input logic [31:0] data);
      in_valid  = 1'b1;
      demuxFlag = flag;
      w_demuxIn = data;
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      demuxFlag = 3'd0;
      w_demuxIn = '0;
      out_ack   = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".valid"}, 32'(out_valid), 32'h0);
      check({tag, ".d0"}, w_demuxOut0, 32'h0);
      check({tag, ".d1"}, w_demuxOut1, 32'h0);
      check({tag, ".d2"}, w_demuxOut2, 32'h0);
      check({tag, ".d3"}, w_demuxOut3, 32'h0);
      check({tag, ".d4"}, w_demuxOut4, 32'h0);
      check({tag, ".serr"}, 32'(sel_err), 32'h0);
      check({tag, ".ecnt"}, 32'(err_count), 32'h0);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
      check_all_zero("rst");

      // First word to channel 2
      offer(3'd2, 32'hDEADBEEF);
      check("w1.rdy", 32'(in_ready), 32'h1);
      tick();
      idle();
      check("w1.valid", 32'(out_valid), 32'h04);
      check("w1.d2", w_demuxOut2, 32'hDEADBEEF);
      check("w1.d0", w_demuxOut0, 32'h0);
      check("w1.d4", w_demuxOut4, 32'h0);
      check("w1.serr", 32'(sel_err), 32'h0);
      check("w1.ecnt", 32'(err_count), 32'h0);

      // Full channel blocks, independent of in_valid
      #1;
      demuxFlag = 3'd2;
      #1;
      check("blk.rdy_noval", 32'(in_ready), 32'h0);
      offer(3'd2, 32'hCAFEF00D);
      check("blk.rdy", 32'(in_ready), 32'h0);
      tick();
      check("blk.d2", w_demuxOut2, 32'hDEADBEEF);
      check("blk.valid", 32'(out_valid), 32'h04);

      // Ack plus new write in the same cycle
      out_ack = 5'b00100;
      offer(3'd2, 32'h12345678);
      check("ackw.rdy", 32'(in_ready), 32'h1);
      tick();
      idle();
      check("ackw.valid", 32'(out_valid), 32'h04);
      check("ackw.d2", w_demuxOut2, 32'h12345678);

      // Ack alone empties; data retained
      out_ack = 5'b00100;
      tick();
      idle();
      check("ack2.valid", 32'(out_valid), 32'h0);
      check("ack2.d2", w_demuxOut2, 32'h12345678);

      // Acks to empty channels are ignored
      out_ack = 5'b11111;
      tick();
      idle();
      check("ackempty.valid", 32'(out_valid), 32'h0);

      // Back-to-back words to 0, 1, 3, 4
      offer(3'd0, 32'hA0A0A0A0);
      tick();
      check("b2b.v0", 32'(out_valid), 32'h01);
      offer(3'd1, 32'hA1A1A1A1);
      tick();
      check("b2b.v1", 32'(out_valid), 32'h03);
      check("b2b.serr1", 32'(sel_err), 32'h0);
      offer(3'd3, 32'hA3A3A3A3);
      tick();
      check("b2b.v3", 32'(out_valid), 32'h0B);
      offer(3'd4, 32'hA4A4A4A4);
      tick();
      idle();
      check("b2b.v4", 32'(out_valid), 32'h1B);
      check("b2b.serr4", 32'(sel_err), 32'h0);
      check("b2b.d0", w_demuxOut0, 32'hA0A0A0A0);
      check("b2b.d1", w_demuxOut1, 32'hA1A1A1A1);
      check("b2b.d2", w_demuxOut2, 32'h12345678);
      check("b2b.d3", w_demuxOut3, 32'hA3A3A3A3);
      check("b2b.d4", w_demuxOut4, 32'hA4A4A4A4);

      // Multi-channel ack
      out_ack = 5'b11011;
      tick();
      idle();
      check("mack.valid", 32'(out_valid), 32'h0);
      check("mack.d0", w_demuxOut0, 32'hA0A0A0A0);
      check("mack.d4", w_demuxOut4, 32'hA4A4A4A4);

      // Hold channel 0 full, then an illegal word must leave it alone
      offer(3'd0, 32'h55555555);
      tick();
      offer(3'd6, 32'h99999999);
      check("ill.rdy", 32'(in_ready), 32'h1);
      tick();
      idle();
      check("ill.serr", 32'(sel_err), 32'h1);
      check("ill.ecnt", 32'(err_count), 32'h1);
      check("ill.valid", 32'(out_valid), 32'h01);
      check("ill.d0", w_demuxOut0, 32'h55555555);
      check("ill.d1", w_demuxOut1, 32'hA1A1A1A1);

      // Illegal select without in_valid has no effect
      demuxFlag = 3'd7;
      tick();
      check("noval.serr", 32'(sel_err), 32'h0);
      check("noval.ecnt", 32'(err_count), 32'h1);

      // Twenty further illegal words saturate the counter
      for (int i = 0; i < 20; i++) begin
         offer(3'd5, 32'(i));
         tick();
         if (i == 12) begin
            check("sat.ecnt14", 32'(err_count), 32'hE);
         end
      end
      idle();
      check("sat.ecnt", 32'(err_count), 32'hF);
      check("sat.serr", 32'(sel_err), 32'h1);
      check("sat.valid", 32'(out_valid), 32'h01);
      tick();
      check("sat.serr_end", 32'(sel_err), 32'h0);
      check("sat.ecnt_hold", 32'(err_count), 32'hF);

      // Build channels 0 and 4 full with err_count = 3, then reset mid-traffic
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_all_zero("rst2");
      offer(3'd0, 32'h0000C0C0);
      tick();
      offer(3'd4, 32'h0000C4C4);
      tick();
      for (int i = 0; i < 3; i++) begin
         offer(3'd7, 32'hEEEEEEEE);
         tick();
      end
      check("pre.ecnt", 32'(err_count), 32'h3);
      check("pre.valid", 32'(out_valid), 32'h11);
      check("pre.d4", w_demuxOut4, 32'h0000C4C4);
      reset = 1'b1;
      offer(3'd1, 32'h77777777);
      tick();
      reset = 1'b0;
      idle();
      check_all_zero("rst3");
      tick();
      check("rst3.post_valid", 32'(out_valid), 32'h0);
      check("rst3.post_d1", w_demuxOut1, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
